// File: rtl/cpu_control.sv
// Fetch/latch/execute sequencer and ALU for a 16-bit Hack-style CPU.
// Drives the A/D/M memory block load enables and data bus; owns PC, halt detection and retired count.
module cpu_control #(
    parameter int PC_W = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    output logic            rom_en,
    input  logic [15:0]     rom_data,
    input  logic [15:0]     reg_a_out,
    input  logic [15:0]     reg_d_out,
    input  logic [15:0]     reg_m_out,
    output logic            reg_a_en,
    output logic            reg_d_en,
    output logic            reg_m_en,
    output logic [15:0]     data_out,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic [15:0]     retired
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;
    logic            prev_a_q, prev_a_d;
    logic            halted_q, halted_d;
    logic [15:0]     retired_q, retired_d;

    logic [15:0]     alu_x, alu_y, alu_out;
    logic            is_c, in_exec, zr, ng, take, self_loop;
    logic [PC_W-1:0] target, pc_inc, pc_dec;

    // NOTE: combinational blocks use blocking '=' and assign every variable a default
    // first, so each path is fully specified and no latch can be inferred.
    always_comb begin
        alu_x = reg_d_out;
        alu_y = ir_q[12] ? reg_m_out : reg_a_out;
        if (ir_q[11]) alu_x = '0;
        if (ir_q[10]) alu_x = ~alu_x;
        if (ir_q[9])  alu_y = '0;
        if (ir_q[8])  alu_y = ~alu_y;
        alu_out = ir_q[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ir_q[6])  alu_out = ~alu_out;
    end

    assign is_c    = ir_q[15];
    assign in_exec = (state_q == S_EXEC);
    assign zr      = (alu_out == 16'h0000);
    assign ng      = alu_out[15];
    assign take    = is_c & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~zr & ~ng));

    // Jump target and loop detection use A as it stood before this instruction's writes.
    assign target    = reg_a_out[PC_W-1:0];
    assign pc_inc    = pc_q + 1'b1;
    assign pc_dec    = pc_q - 1'b1;
    assign self_loop = take & ((target == pc_q) | ((target == pc_dec) & prev_a_q));

    always_comb begin
        data_out = 16'h0000;
        reg_a_en = 1'b0;
        reg_d_en = 1'b0;
        reg_m_en = 1'b0;
        if (in_exec) begin
            data_out = is_c ? alu_out : {1'b0, ir_q[14:0]};
            // Reset blocks writes in the same cycle, even mid-EXEC.
            reg_a_en = ~rst & (is_c ? ir_q[5] : 1'b1);
            reg_d_en = ~rst & is_c & ir_q[4];
            reg_m_en = ~rst & is_c & ir_q[3];
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        prev_a_d  = prev_a_q;
        halted_d  = halted_q;
        retired_d = retired_q;
        case (state_q)
            S_FETCH: if (run) state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = rom_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                retired_d = retired_q + 16'd1;
                prev_a_d  = ~ir_q[15];
                if (self_loop) begin
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else begin
                    pc_d    = take ? target : pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // NOTE: sequential state uses non-blocking '<=' so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            ir_q      <= 16'h0000;
            prev_a_q  <= 1'b0;
            halted_q  <= 1'b0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            prev_a_q  <= prev_a_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

    assign rom_en   = (state_q == S_FETCH) & run;
    assign rom_addr = pc_q;
    assign pc       = pc_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_cpu_control.sv
// Scoreboard bench for cpu_control: ROM and A/D/M memory block modelled around the DUT,
// expected bus transactions queued by stimulus and compared by an independent monitor.
module tb_cpu_control;

    localparam int PC_W = 15;

    logic            clk = 1'b0;
    logic            rst, run;
    logic [PC_W-1:0] rom_addr;
    logic            rom_en;
    logic [15:0]     rom_data;
    logic [15:0]     tb_a, tb_d, tb_m;
    logic            reg_a_en, reg_d_en, reg_m_en;
    logic [15:0]     data_out;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic [15:0]     retired;

    logic [15:0] rom    [0:32767];
    logic [15:0] tb_mem [0:65535];

    typedef struct packed {
        logic        a_en;
        logic        d_en;
        logic        m_en;
        logic [15:0] data;
    } bus_t;

    bus_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_control #(.PC_W(PC_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .rom_addr (rom_addr),
        .rom_en   (rom_en),
        .rom_data (rom_data),
        .reg_a_out(tb_a),
        .reg_d_out(tb_d),
        .reg_m_out(tb_m),
        .reg_a_en (reg_a_en),
        .reg_d_en (reg_d_en),
        .reg_m_en (reg_m_en),
        .data_out (data_out),
        .pc       (pc),
        .halted   (halted),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    // Registered-read ROM and the A/D/M memory block.
    assign tb_m = tb_mem[tb_a];
    always @(posedge clk) begin
        if (rom_en)   rom_data <= rom[rom_addr];
        if (reg_a_en) tb_a <= data_out;
        if (reg_d_en) tb_d <= data_out;
        if (reg_m_en) tb_mem[tb_a] <= data_out;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every cycle with a load enable is a bus transaction.
    always @(negedge clk) begin
        if (reg_a_en | reg_d_en | reg_m_en) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected", {13'd0, reg_a_en, reg_d_en, reg_m_en, data_out}, 32'hFFFF_FFFF);
            end else begin
                bus_t e;
                e = sb_q.pop_front();
                check("sb_bus", {13'd0, reg_a_en, reg_d_en, reg_m_en, data_out}, {13'd0, e});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        ticks(2);
        rst = 1'b0;
    endtask

    task automatic step();
        run = 1'b1;
        tick();
        run = 1'b0;
        ticks(2);
    endtask

    task automatic expect_bus(input logic a, input logic d, input logic m, input logic [15:0] v);
        bus_t e;
        e = '{a_en: a, d_en: d, m_en: m, data: v};
        sb_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [6:0]  comp_tab [22] = '{7'b0101010, 7'b0111111, 7'b0111010, 7'b0001100, 7'b0110000,
                                   7'b0001101, 7'b0110001, 7'b0001111, 7'b0110011, 7'b0011111,
                                   7'b0110111, 7'b0001110, 7'b0110010, 7'b0000010, 7'b0010011,
                                   7'b0000111, 7'b0000000, 7'b0010101, 7'b1110000, 7'b1000010,
                                   7'b1010011, 7'b1000000};
    logic [15:0] alu_exp  [22] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h1234, 16'h00FF,
                                   16'hEDCB, 16'hFF00, 16'hEDCC, 16'hFF01, 16'h1235,
                                   16'h0100, 16'h1233, 16'h00FE, 16'h1333, 16'h1135,
                                   16'hEECB, 16'h0034, 16'h12FF, 16'hFFFF, 16'h1233,
                                   16'h1235, 16'h1234};

    initial begin
        for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;
        for (int i = 0; i < 65536; i++) tb_mem[i] <= 16'h0000;
        tb_a <= 16'h0000;
        tb_d <= 16'h0000;
        rst = 1'b1;
        run = 1'b0;

        // Reset state
        do_reset();
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_idle_rom_en", 32'(rom_en), 0);
        check("rst_bus", {13'd0, reg_a_en, reg_d_en, reg_m_en, data_out}, 0);

        // Single A-instruction
        rom[0] = 16'h0005;
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0005);
        run = 1'b1;
        #1;
        check("t1_rom_en_fetch", 32'(rom_en), 1);
        tick();
        check("t1_rom_en_latch", 32'(rom_en), 0);
        run = 1'b0;
        ticks(2);
        check("t1_pc", 32'(pc), 1);
        check("t1_retired", 32'(retired), 1);

        // Back-to-back: @7, D=A, M=D+1 in 9 cycles
        do_reset();
        rom[0] = 16'h0007;
        rom[1] = 16'hEC10;
        rom[2] = 16'hE7C8;
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0007);
        expect_bus(1'b0, 1'b1, 1'b0, 16'h0007);
        expect_bus(1'b0, 1'b0, 1'b1, 16'h0008);
        run = 1'b1;
        ticks(9);
        run = 1'b0;
        tick();
        check("t2_d", 32'(tb_d), 7);
        check("t2_mem7", 32'(tb_mem[7]), 8);
        check("t2_pc", 32'(pc), 3);
        check("t2_retired", 32'(retired), 3);

        // Conditional jumps
        do_reset();
        rom[0]  = 16'hE301;
        rom[10] = 16'hE301;
        rom[11] = 16'hE301;
        rom[12] = 16'hE304;
        tb_a <= 16'd10;
        tb_d <= 16'd5;
        step();
        check("t3_jgt_taken", 32'(pc), 10);
        tb_d <= 16'h0000;
        step();
        check("t3_jgt_zero", 32'(pc), 11);
        tb_d <= 16'h8000;
        step();
        check("t3_jgt_neg", 32'(pc), 12);
        step();
        check("t3_jlt_taken", 32'(pc), 10);
        check("t3_retired", 32'(retired), 4);

        // Halt on @4 ; 0;JMP at pc 5 (target = pc-1 after A-instr)
        do_reset();
        rom[0] = 16'h0004;
        rom[1] = 16'hEA87;
        rom[4] = 16'h0004;
        rom[5] = 16'hEA87;
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0004);
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0004);
        run = 1'b1;
        ticks(12);
        check("t4_halted", 32'(halted), 1);
        check("t4_pc", 32'(pc), 5);
        check("t4_retired", 32'(retired), 4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_halt_rom_en", 32'(rom_en), 0);
        end
        check("t4_pc_frozen", 32'(pc), 5);
        check("t4_retired_frozen", 32'(retired), 4);
        run = 1'b0;

        // target == pc-1 after a C-instr is not a halt; target == pc is
        do_reset();
        rom[0] = 16'h0001;
        rom[1] = 16'hEA80;
        rom[2] = 16'hEA87;
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0001);
        run = 1'b1;
        ticks(9);
        run = 1'b0;
        check("t4b_no_halt", 32'(halted), 0);
        check("t4b_pc", 32'(pc), 1);
        rom[1] = 16'hEA87;
        step();
        check("t4b_self_halt", 32'(halted), 1);
        check("t4b_self_pc", 32'(pc), 1);

        // PC wrap at 2**PC_W
        do_reset();
        rom[0]     = 16'h7FFF;
        rom[1]     = 16'hEA87;
        rom[32767] = 16'h0003;
        expect_bus(1'b1, 1'b0, 1'b0, 16'h7FFF);
        expect_bus(1'b1, 1'b0, 1'b0, 16'h0003);
        run = 1'b1;
        ticks(6);
        check("t5_jump_top", 32'(pc), 32'h7FFF);
        ticks(3);
        run = 1'b0;
        check("t5_wrap_pc", 32'(pc), 0);
        check("t5_wrap_halted", 32'(halted), 0);

        // ALU sweep, D=0x1234 A=0x00FF M=0xFFFF, result written to M
        do_reset();
        for (int i = 0; i < 22; i++) begin
            logic [6:0] c;
            c = comp_tab[i];
            tb_d <= 16'h1234;
            tb_a <= 16'h00FF;
            tb_mem[255] <= 16'hFFFF;
            rom[i] = {3'b111, c, 3'b001, 3'b000};
            expect_bus(1'b0, 1'b0, 1'b1, alu_exp[i]);
            step();
        end
        check("t6_sweep_pc", 32'(pc), 22);
        check("t6_sweep_retired", 32'(retired), 22);

        // Reset asserted during EXEC of M=D+1
        do_reset();
        tb_a <= 16'd7;
        tb_d <= 16'd3;
        tb_mem[7] <= 16'h0055;
        rom[0] = 16'hE7C8;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("t7_m_en_gated", 32'(reg_m_en), 0);
        tick();
        rst = 1'b0;
        check("t7_mem7", 32'(tb_mem[7]), 32'h55);
        check("t7_pc", 32'(pc), 0);
        check("t7_retired", 32'(retired), 0);
        ticks(3);
        check("t7_idle_rom_en", 32'(rom_en), 0);
        check("t7_idle_pc", 32'(pc), 0);
        run = 1'b1;
        #1;
        check("t7_fetch_rom_en", 32'(rom_en), 1);
        run = 1'b0;

        ticks(2);
        check("sb_drain", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
